// File: rtl/single_port_sync_ram_be_if.sv
// single_port_sync_ram_be_if: request/response bus of the byte-enable single-port RAM
interface single_port_sync_ram_be_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                    cs;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rvalid;
  logic                    ready;
  modport master (output cs, we, be, addr, wdata, input rdata, rvalid, ready);
  modport slave (input cs, we, be, addr, wdata, output rdata, rvalid, ready);
endinterface

// File: rtl/single_port_sync_ram_be.sv
// single_port_sync_ram_be: byte-enable single-port RAM with post-reset clear and 1/2-cycle read latency
module single_port_sync_ram_be #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 4,
  parameter int                    DEPTH        = 16,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input logic                      clk,
  input logic                      rst_n,
  single_port_sync_ram_be_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  typedef enum logic {CLEAR, RUN} state_e;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic                  v1_q, v1_d, v2_q, v3_q;
  logic                  clr, acc, wr, in_range;
  always_comb begin
    clr      = state_q == CLEAR;
    acc      = bus.cs && !clr;
    in_range = {1'b0, bus.addr} < (ADDR_WIDTH + 1)'(DEPTH);
    wr       = acc && bus.we && in_range;
    state_d  = clr && ptr_q == LAST ? RUN : state_q;
    ptr_d    = clr ? ptr_q + 1'b1 : ptr_q;
    v1_d     = acc && !bus.we;
    d1_d     = v1_d ? (in_range ? mem_q[bus.addr] : '0) : d1_q;
    d2_d     = v1_q ? d1_q : d2_q;
    d3_d     = v2_q ? d2_q : d3_q;
  end
  // Array has no reset; the clear sequence initialises it after every reset.
  always_ff @(posedge clk) begin
    if (clr) mem_q[ptr_q] <= INIT_VALUE;
    else if (wr)
      for (int i = 0; i < NB; i++)
        if (bus.be[i]) mem_q[bus.addr][8*i +: 8] <= bus.wdata[8*i +: 8];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      v1_q    <= v1_d;
      v2_q    <= v1_q;
      v3_q    <= v2_q;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
    end
  end
  assign bus.ready  = state_q == RUN;
  assign bus.rvalid = READ_LATENCY == 2 ? v3_q : v2_q;
  assign bus.rdata  = READ_LATENCY == 2 ? d3_q : d2_q;
endmodule

// File: tb/tb_single_port_sync_ram_be.sv
// tb_single_port_sync_ram_be: directed checks of clear, byte enables, latency, range and reset behaviour
module tb_single_port_sync_ram_be;
  logic clk = 1'b0;
  logic rst_n;
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_a [16];
  always #5 clk = ~clk;
  single_port_sync_ram_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) a_if ();
  single_port_sync_ram_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) b_if ();
  single_port_sync_ram_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) c_if ();
  single_port_sync_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .READ_LATENCY(1),
    .INIT_VALUE(32'hA5A5A5A5)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  single_port_sync_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .READ_LATENCY(2),
    .INIT_VALUE(32'h0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
  single_port_sync_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(12), .READ_LATENCY(1),
    .INIT_VALUE(32'h12345678)) dut_c (.clk(clk), .rst_n(rst_n), .bus(c_if));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  // Back-to-back reads of dut_a words 0..15, checked against exp_a.
  task automatic sweep_a(input string tag);
    a_if.cs = 1'b1;
    a_if.we = 1'b0;
    a_if.addr = 4'd0;
    for (int j = 0; j <= 16; j++) begin
      tick();
      if (j == 0) chk({tag, "_first_rvalid"}, 32'(a_if.rvalid), 32'd0);
      else begin
        chk({tag, "_rvalid"}, 32'(a_if.rvalid), 32'd1);
        chk($sformatf("%s_rdata%0d", tag, j - 1), a_if.rdata, exp_a[j-1]);
      end
      if (j < 15) a_if.addr = 4'(j + 1);
      else a_if.cs = 1'b0;
    end
    tick();
    chk({tag, "_rvalid_end"}, 32'(a_if.rvalid), 32'd0);
  endtask
  initial begin
    {a_if.cs, a_if.we, a_if.be, a_if.addr, a_if.wdata} = '0;
    {b_if.cs, b_if.we, b_if.be, b_if.addr, b_if.wdata} = '0;
    {c_if.cs, c_if.we, c_if.be, c_if.addr, c_if.wdata} = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(a_if.ready), 32'd0);
    chk("rst_rvalid", 32'(a_if.rvalid), 32'd0);
    chk("rst_rdata", a_if.rdata, 32'd0);
    chk("rst_b_rvalid", 32'(b_if.rvalid), 32'd0);
    // Write driven throughout the clear sequence must be dropped.
    a_if.cs = 1'b1; a_if.we = 1'b1; a_if.be = 4'hF; a_if.addr = 4'd3; a_if.wdata = 32'h0;
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("clr_a_ready_e%0d", k), 32'(a_if.ready), 32'(k == 16));
      chk($sformatf("clr_c_ready_e%0d", k), 32'(c_if.ready), 32'(k >= 12));
    end
    a_if.cs = 1'b0;
    for (int j = 0; j < 16; j++) exp_a[j] = 32'hA5A5A5A5;
    sweep_a("clear");
    a_if.cs = 1'b1; a_if.we = 1'b1; a_if.be = 4'hF; a_if.addr = 4'd5; a_if.wdata = 32'h11223344;
    tick();
    a_if.be = 4'b0101; a_if.wdata = 32'hAABBCCDD;
    tick();
    a_if.we = 1'b0;
    tick();
    a_if.cs = 1'b0;
    tick();
    chk("be_rvalid", 32'(a_if.rvalid), 32'd1);
    chk("be_rdata", a_if.rdata, 32'h11BB33DD);
    tick();
    chk("be_rdata_hold", a_if.rdata, 32'h11BB33DD);
    chk("be_rvalid_fall", 32'(a_if.rvalid), 32'd0);
    a_if.cs = 1'b1; a_if.we = 1'b1; a_if.be = 4'hF;
    for (int j = 0; j < 16; j++) begin
      exp_a[j] = $urandom;
      a_if.addr = 4'(j);
      a_if.wdata = exp_a[j];
      tick();
    end
    chk("write_no_rvalid", 32'(a_if.rvalid), 32'd0);
    chk("write_rdata_hold", a_if.rdata, 32'h11BB33DD);
    sweep_a("sweep");
    b_if.cs = 1'b1; b_if.we = 1'b1; b_if.be = 4'hF; b_if.addr = 4'd7; b_if.wdata = 32'hDEADBEEF;
    tick();
    chk("l2_rvalid_n", 32'(b_if.rvalid), 32'd0);
    b_if.we = 1'b0;
    tick();
    chk("l2_rvalid_n1", 32'(b_if.rvalid), 32'd0);
    b_if.cs = 1'b0;
    tick();
    chk("l2_rvalid_n2", 32'(b_if.rvalid), 32'd0);
    tick();
    chk("l2_rvalid_n3", 32'(b_if.rvalid), 32'd1);
    chk("l2_rdata_n3", b_if.rdata, 32'hDEADBEEF);
    tick();
    chk("l2_rvalid_n4", 32'(b_if.rvalid), 32'd0);
    c_if.cs = 1'b1; c_if.we = 1'b1; c_if.be = 4'hF; c_if.addr = 4'd13; c_if.wdata = 32'hFFFFFFFF;
    tick();
    c_if.we = 1'b0; c_if.addr = 4'd11;
    tick();
    c_if.addr = 4'd13;
    tick();
    chk("oor_rd11a", c_if.rdata, 32'h12345678);
    c_if.addr = 4'd11;
    tick();
    chk("oor_rd13_rvalid", 32'(c_if.rvalid), 32'd1);
    chk("oor_rd13", c_if.rdata, 32'h0);
    c_if.cs = 1'b0;
    tick();
    chk("oor_rd11b", c_if.rdata, 32'h12345678);
    a_if.cs = 1'b1; a_if.we = 1'b0; a_if.addr = 4'd5;
    tick();
    a_if.cs = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(a_if.rvalid), 32'd0);
    chk("mid_rst_rdata", a_if.rdata, 32'd0);
    chk("mid_rst_ready", 32'(a_if.ready), 32'd0);
    tick();
    chk("mid_rst_rvalid_hold", 32'(a_if.rvalid), 32'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("reclr_ready_e%0d", k), 32'(a_if.ready), 32'(k == 16));
      chk($sformatf("reclr_rvalid_e%0d", k), 32'(a_if.rvalid), 32'd0);
    end
    for (int j = 0; j < 16; j++) exp_a[j] = 32'hA5A5A5A5;
    sweep_a("reclear");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
